write_to_fifo_bridge: RTL and testbench
=======================================

# write_to_fifo_bridge

Register-mapped byte-pair loader for the AES custom-logic wrapper. It accepts AXI-Lite-style single-cycle writes and shifts each write's key byte and data byte into a 16-entry history FIFO. A tagged final write freezes the last 16 entries into a 128-bit key and a 128-bit data block. Both blocks, status, a scratch register and the LED value are readable over a simple read channel.

## Interface
- `WR_ADDR_LOAD`, default 32'h0000_0510: address that pushes byte pairs.
- `WR_ADDR_HELLO`, default 32'h0000_0500: scratch register write address.
- `LOAD_TAG`, default 16'h1111: `wdata[31:16]` value marking the final byte pair.
- Ports:
  - `clk_main_a0`  in  1  single clock; all state updates on the rising edge.
  - `rst_main_n_sync`  in  1  asynchronous, active-high reset.
  - `wr_addr`  in  32  write address.
  - `wready`  in  1  write strobe; each cycle it is high is one accepted write.
  - `wdata`  in  32  write data: [31:16] tag, [15:8] key byte, [7:0] data byte.
  - `rready`  in  1  read-data accept.
  - `arvalid_q`  in  1  read address valid.
  - `araddr_q`  in  32  read address.
  - `vled_q`  in  16  LED value, read-only mirror.
  - `rresp`  out  2  read response; constant 2'b00.
  - `rvalid`  out  1  read data valid.
  - `rdata`  out  32  read data.
  - `hello_world_q`  out  32  scratch register.

## Operation
- Load write: `wready` high and `wr_addr`==`WR_ADDR_LOAD`.
  - Shift the 16-bit pair {`wdata[15:8]`,`wdata[7:0]`} into entry 0 of a 16×16 shift FIFO; entry 15 is discarded.
  - `count` increments and saturates at 16.
- Tag write: a load write with `wdata[31:16]`==`LOAD_TAG`.
  - If the count after this push is ≥16: latch `key_q` = key bytes of entries 15..0 (entry 15 is the oldest, in [127:120]) and `din_q` = data bytes likewise, including the current pair at [7:0]. Then set `done`=1 and clear `err`.
  - Otherwise set `err`=1; `done`, `key_q` and `din_q` are unchanged.
- A later load write does not clear `done`. Only reset or a new tag write changes `done`, `key_q`, `din_q` or `err`.
- Hello write: `wready` high and `wr_addr`==`WR_ADDR_HELLO` sets `hello_world_q` <= `wdata`.
- Writes to any other address are ignored.
- Read map (byte addresses):
  - 0x500: `hello_world_q`.
  - 0x504: {16'h0, `vled_q`}.
  - 0x510: status {last tag [31:16], 7'b0, count [8:4], 2'b0, `err` [1], `done` [0]}.
  - 0x520/524/528/52C: `key_q` [127:96]/[95:64]/[63:32]/[31:0].
  - 0x530/534/538/53C: `din_q`, same slicing.
  - Any other address: 32'hDEAD_BEEF.
- Last tag is `wdata[31:16]` of the most recent load write.
- `rresp` is always OKAY (2'b00).

## Timing
- Reset values: `hello_world_q`=0, `rvalid`=0, `rdata`=0, `rresp`=0. Internally `count`=0, `done`=0, `err`=0, and FIFO, `key_q`, `din_q` and last tag are all 0.
- Reset asserted mid-operation clears everything immediately, with no partial latch.
- Writes:
  - No backpressure; one accepted write per cycle.
  - FIFO, `count`, `done`/`err`, `key_q`/`din_q` and `hello_world_q` update on the edge that samples the write and are visible the next cycle.
- Read handshake:
  - When `rvalid`=0 and `arvalid_q`=1 at an edge, the address is accepted; `rvalid`=1 and `rdata` = the map value from pre-edge register state on that edge.
  - `rvalid` and `rdata` hold until an edge with `rready`=1; there `rvalid` goes to 0.
  - No new address is accepted in the cycle `rvalid` drops. With `arvalid_q` held high, reads repeat every 2 cycles at best.
- Simultaneous write and read: the read returns pre-write values. For example, a status read accepted on the tag-write edge shows `done`=0.
- Garbage writes (e.g. undefined `wdata` in the first cycle) simply age out once 16 newer pairs arrive.

## Test plan
- Reset, then read 0x510 with `rready`=1 → `rvalid` rises 1 cycle after `arvalid_q`; `rdata`=0, `rresp`=0.
- Stream 16 load writes at 0x510, one per cycle, key bytes 00..0F and data bytes 00,11,…,FF, with the last carrying tag 0x1111.
  - Status → 0x1111_0101.
  - 0x520 → 0x00010203, 0x52C → 0x0C0D0E0F.
  - 0x530 → 0x00112233, 0x53C → 0xCCDDEEFF.
- Same stream preceded by one junk write (17 writes) → identical `key_q`/`din_q`; count saturates at 16.
- Tag on the 5th write after reset → status `err`=1, `done`=0, `key_q`=0.
- Write 0x12345678 at 0x500 → `hello_world_q`=0x12345678 the next cycle; a read of 0x500 returns it. A read of 0x504 with `vled_q`=0xA5A5 → 0x0000A5A5. A read of 0x600 → 0xDEADBEEF.
- Hold `rready`=0 for 5 cycles after `rvalid` → `rvalid` and `rdata` stay stable. Assert reset mid-read → `rvalid`=0 immediately.

Source files
------------

// File: rtl/write_to_fifo_bridge.sv
// Register-mapped byte-pair loader: shifts {key,data} byte pairs into a 16-deep
// history FIFO and freezes it into 128-bit key/data blocks on a tagged write.
module write_to_fifo_bridge #(
  parameter logic [31:0] WR_ADDR_LOAD  = 32'h0000_0510,
  parameter logic [31:0] WR_ADDR_HELLO = 32'h0000_0500,
  parameter logic [15:0] LOAD_TAG      = 16'h1111
) (
  input  logic        clk_main_a0,
  input  logic        rst_main_n_sync,
  input  logic [31:0] wr_addr,
  input  logic        wready,
  input  logic [31:0] wdata,
  input  logic        rready,
  input  logic        arvalid_q,
  input  logic [31:0] araddr_q,
  input  logic [15:0] vled_q,
  output logic [1:0]  rresp,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic [31:0] hello_world_q
);
  localparam int DEPTH = 16;

  logic [DEPTH-1:0][15:0] fifo, fifo_nxt;
  logic [4:0]             count, count_nxt;
  logic [15:0]            last_tag;
  logic                   done, err;
  logic [127:0]           key_q, din_q, key_nxt, din_nxt;
  logic                   load, tag;
  logic [31:0]            rd_val;

  assign load  = wready && (wr_addr == WR_ADDR_LOAD);
  assign tag   = load && (wdata[31:16] == LOAD_TAG);
  assign rresp = 2'b00;

  // Key/data blocks are taken from the post-push FIFO so the tagged pair lands at [7:0].
  always_comb begin
    fifo_nxt  = {fifo[DEPTH-2:0], wdata[15:0]};
    count_nxt = (count == 5'd16) ? 5'd16 : count + 5'd1;
    key_nxt   = '0;
    din_nxt   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      key_nxt[i*8 +: 8] = fifo_nxt[i][15:8];
      din_nxt[i*8 +: 8] = fifo_nxt[i][7:0];
    end
  end

  always_ff @(posedge clk_main_a0 or posedge rst_main_n_sync) begin
    if (rst_main_n_sync) begin
      fifo          <= '0;
      count         <= '0;
      last_tag      <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      key_q         <= '0;
      din_q         <= '0;
      hello_world_q <= '0;
    end else begin
      if (load) begin
        fifo     <= fifo_nxt;
        count    <= count_nxt;
        last_tag <= wdata[31:16];
      end
      if (tag) begin
        if (count_nxt >= 5'd16) begin
          key_q <= key_nxt;
          din_q <= din_nxt;
          done  <= 1'b1;
          err   <= 1'b0;
        end else begin
          err   <= 1'b1;
        end
      end
      if (wready && (wr_addr == WR_ADDR_HELLO))
        hello_world_q <= wdata;
    end
  end

  always_comb begin
    rd_val = 32'hDEAD_BEEF;
    case (araddr_q)
      32'h0000_0500: rd_val = hello_world_q;
      32'h0000_0504: rd_val = {16'h0, vled_q};
      32'h0000_0510: rd_val = {last_tag, 7'b0, count, 2'b0, err, done};
      32'h0000_0520: rd_val = key_q[127:96];
      32'h0000_0524: rd_val = key_q[95:64];
      32'h0000_0528: rd_val = key_q[63:32];
      32'h0000_052C: rd_val = key_q[31:0];
      32'h0000_0530: rd_val = din_q[127:96];
      32'h0000_0534: rd_val = din_q[95:64];
      32'h0000_0538: rd_val = din_q[63:32];
      32'h0000_053C: rd_val = din_q[31:0];
      default:       rd_val = 32'hDEAD_BEEF;
    endcase
  end

  // Address is only taken while idle, so the cycle rvalid drops never accepts a new one.
  always_ff @(posedge clk_main_a0 or posedge rst_main_n_sync) begin
    if (rst_main_n_sync) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (!rvalid && arvalid_q) begin
      rvalid <= 1'b1;
      rdata  <= rd_val;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_write_to_fifo_bridge.sv
// Scoreboard bench for write_to_fifo_bridge: read expectations are queued at
// issue time and compared when the read response is handed over.
module tb_write_to_fifo_bridge;
  logic        clk = 0;
  logic        rst = 1;
  logic [31:0] wr_addr = 0;
  logic        wready = 0;
  logic [31:0] wdata = 0;
  logic        rready = 1;
  logic        arvalid_q = 0;
  logic [31:0] araddr_q = 0;
  logic [15:0] vled_q = 0;
  logic [1:0]  rresp;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] hello_world_q;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  write_to_fifo_bridge dut (
    .clk_main_a0(clk), .rst_main_n_sync(rst), .wr_addr(wr_addr), .wready(wready),
    .wdata(wdata), .rready(rready), .arvalid_q(arvalid_q), .araddr_q(araddr_q),
    .vled_q(vled_q), .rresp(rresp), .rvalid(rvalid), .rdata(rdata),
    .hello_world_q(hello_world_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Response is consumed on the next edge when rready is high.
  always @(negedge clk) begin
    if (!rst && rvalid && rready) begin
      if (exp_q.size() == 0) chk("unexpected_rvalid", 32'd1, 32'd0);
      else chk("rdata", rdata, exp_q.pop_front());
      chk("rresp", {30'd0, rresp}, 32'd0);
    end
  end

  task automatic do_reset();
    rst = 1; tick(); rst = 0; tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wready = 1; wr_addr = a; wdata = d; tick(); wready = 0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 10 && rvalid; n++) tick();
    if (rvalid) chk("rd_timeout", 32'd1, 32'd0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    chk("rvalid_idle", {31'd0, rvalid}, 32'd0);
    arvalid_q = 1; araddr_q = a; tick(); arvalid_q = 0;
    chk("rvalid_rise", {31'd0, rvalid}, 32'd1);
    wait_idle();
  endtask

  task automatic stream(input logic [15:0] last_tag);
    for (int i = 0; i < 16; i++)
      wr(32'h510, {(i == 15) ? last_tag : 16'h0, i[7:0], 8'(i * 8'h11)});
  endtask

  task automatic chk_blocks();
    rd(32'h520, 32'h0001_0203); rd(32'h524, 32'h0405_0607);
    rd(32'h528, 32'h0809_0A0B); rd(32'h52C, 32'h0C0D_0E0F);
    rd(32'h530, 32'h0011_2233); rd(32'h534, 32'h4455_6677);
    rd(32'h538, 32'h8899_AABB); rd(32'h53C, 32'hCCDD_EEFF);
  endtask

  initial begin
    tick(); tick();
    chk("rst_hello", hello_world_q, 32'h0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rresp", {30'd0, rresp}, 32'd0);
    rst = 0; tick();
    rd(32'h510, 32'h0);

    // 16-pair stream with tag on the last write
    stream(16'h1111);
    rd(32'h510, 32'h1111_0101);
    chk_blocks();
    wr(32'h510, 32'h0000_9988);
    rd(32'h510, 32'h0000_0101);
    rd(32'h520, 32'h0001_0203);

    // junk write ahead of the stream ages out; count saturates
    do_reset();
    wr(32'h510, 32'h0000_ABCD);
    stream(16'h1111);
    rd(32'h510, 32'h1111_0101);
    chk_blocks();

    // early tag sets err only; a later valid tag clears it
    do_reset();
    for (int i = 0; i < 5; i++) wr(32'h510, {(i == 4) ? 16'h1111 : 16'h0, 16'h0101});
    rd(32'h510, 32'h1111_0052);
    rd(32'h520, 32'h0);
    rd(32'h530, 32'h0);
    for (int i = 0; i < 11; i++) wr(32'h510, {(i == 10) ? 16'h1111 : 16'h0, 16'h0202});
    rd(32'h510, 32'h1111_0101);
    rd(32'h52C, 32'h0202_0202);
    rd(32'h520, 32'h0101_0101);

    // scratch, LED mirror, unmapped address
    wr(32'h500, 32'h1234_5678);
    chk("hello_q", hello_world_q, 32'h1234_5678);
    rd(32'h500, 32'h1234_5678);
    vled_q = 16'hA5A5;
    rd(32'h504, 32'h0000_A5A5);
    rd(32'h600, 32'hDEAD_BEEF);
    wr(32'h508, 32'hFFFF_FFFF);
    rd(32'h500, 32'h1234_5678);

    // rready held low: response must stay put
    rready = 0;
    exp_q.push_back(32'h0000_A5A5);
    arvalid_q = 1; araddr_q = 32'h504; tick(); arvalid_q = 0;
    vled_q = 16'h0F0F;
    for (int i = 0; i < 5; i++) begin
      chk("hold_rvalid", {31'd0, rvalid}, 32'd1);
      chk("hold_rdata", rdata, 32'h0000_A5A5);
      tick();
    end
    rready = 1; tick();
    wait_idle();

    // read on the tag-write edge sees pre-write status
    do_reset();
    for (int i = 0; i < 15; i++) wr(32'h510, {16'h0, i[7:0], 8'(i * 8'h11)});
    exp_q.push_back(32'h0000_00F0);
    wready = 1; wr_addr = 32'h510; wdata = 32'h1111_0FFF;
    arvalid_q = 1; araddr_q = 32'h510; tick();
    wready = 0; arvalid_q = 0;
    wait_idle();
    rd(32'h510, 32'h1111_0101);
    rd(32'h53C, 32'hCCDD_EEFF);

    // reset mid-read drops rvalid at once
    rready = 0;
    arvalid_q = 1; araddr_q = 32'h500; tick(); arvalid_q = 0;
    chk("mid_rvalid", {31'd0, rvalid}, 32'd1);
    rst = 1; #1;
    chk("rst_mid_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_mid_rdata", rdata, 32'h0);
    tick(); rst = 0; rready = 1; tick();
    rd(32'h510, 32'h0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
